uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmit path (TX FIFO plus UART transmitter) between NUM_REQ byte-stream requesters.
- Grants the FIFO write port to one requester at a time and holds the grant for a whole message (until `last`), so bytes from different requesters never interleave on the line.
- Sits directly in front of the TX wrapper's `wr_en`/`data_in`/`full` port and drives its `tx_enable`.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, byte width
- MAX_BURST, 16, max bytes per grant before forced release (power of 2, ≥2)

Ports:
- UART_clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester byte; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  marks final byte of a message
- req_ready  out  NUM_REQ  one-hot/zero accept; byte transfers when valid&ready
- arb_enable  in  1  allows new grants; does not abort an active grant
- fifo_full  in  1  TX FIFO full
- fifo_wr_en  out  1  TX FIFO write strobe
- fifo_data  out  DATA_WIDTH  TX FIFO write data
- tx_enable  out  1  UART transmitter enable
- grant_valid  out  1  a requester currently holds the grant
- grant_id  out  clog2(NUM_REQ)  index of granted requester
- msg_done  out  1  one-cycle pulse when a grant is released
- burst_trunc  out  1  one-cycle pulse when release was forced by MAX_BURST

## Operation
- FSM states:
  - IDLE: no grant held.
  - GRANT: grant held.
- IDLE -> GRANT when arb_enable=1 and any req_valid=1.
  - Winner: first requester with req_valid=1 searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - grant_id and grant_valid are registered on that edge.
  - beat_cnt cleared to 0.
- In GRANT:
  - req_ready[grant_id] = !fifo_full; all other req_ready bits = 0.
  - Beat = req_valid[grant_id] & req_ready[grant_id].
  - fifo_wr_en = beat (combinational).
  - fifo_data = req_data slice of grant_id (combinational; don't-care when fifo_wr_en=0).
- Release: on a beat with req_last[grant_id]=1, or on a beat with beat_cnt=MAX_BURST-1.
  - Next state IDLE.
  - rr_ptr <= (grant_id+1) mod NUM_REQ.
  - msg_done pulses on the following cycle.
  - burst_trunc pulses with msg_done only when req_last=0 on the releasing beat.
- beat_cnt increments on each non-releasing beat; width clog2(MAX_BURST).
- tx_enable = 1 at all times out of reset; 0 during reset.
- Requester with valid low during GRANT keeps the grant (no timeout); the line stalls.
- arb_enable deasserted in GRANT: current message still runs to release; no new grant afterwards until arb_enable=1.
- rr_ptr updates only on release, so an idle period does not shift priority.

## Timing
- Reset (async assert, sync-safe deassert), all registered outputs:
  - state IDLE, rr_ptr 0, beat_cnt 0.
  - grant_valid 0, grant_id 0, msg_done 0, burst_trunc 0.
- Reset outputs, derived:
  - req_ready all 0, fifo_wr_en 0, tx_enable 0.
- Reset mid-message: grant dropped immediately. Partial message bytes already in the FIFO remain (FIFO reset is separate); no further bytes written.
- Grant latency: req_valid seen at edge N -> grant_valid=1 after edge N; first byte can be written in cycle N+1.
- Steady state: 1 byte per cycle while valid=1 and fifo_full=0.
- Release bubble: exactly 1 IDLE cycle between consecutive grants.
- fifo_full is sampled combinationally each cycle, so no write is ever issued while fifo_full=1.
- Simultaneous last and MAX_BURST limit on the same beat: normal release, burst_trunc=0.
- Simultaneous requests in IDLE: only the round-robin winner is granted; others see req_ready=0.

## Test plan
- Single requester, req 2 sends A5,5A,3C (last on 3C) -> grant_id=2 one cycle after valid; fifo_wr_en three consecutive cycles with data A5,5A,3C; msg_done pulse; rr_ptr=3.
- All 4 requesters send one-byte messages continuously from reset -> grant order 0,1,2,3,0; each grant 1 write + 1 IDLE cycle; no interleaving.
- fifo_full forced high for 5 cycles mid-message -> req_ready=0 and fifo_wr_en=0 for exactly those cycles; message resumes with the next byte and no byte is lost or duplicated.
- Requester streams 20 bytes 00..13 with no last, MAX_BURST=16 -> release after byte 0F with burst_trunc=1; the next grant goes to another requester if one is pending, otherwise the same requester is regranted for 10..13.
- arb_enable dropped after first byte of a 4-byte message -> all 4 bytes written, then grant_valid stays 0 despite pending valids until arb_enable=1.
- rst_n asserted mid-message after 2 of 4 bytes -> grant_valid, req_ready and fifo_wr_en go 0 immediately; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port between NUM_REQ byte streams.
// A grant is held for a whole message (until last) or until MAX_BURST bytes have been written.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          UART_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          arb_enable_i,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          tx_enable_o,
  output logic                          grant_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          msg_done_o,
  output logic                          burst_trunc_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  msg_done_q, msg_done_d;
  logic                  burst_trunc_q, burst_trunc_d;

  logic                  win_found_s;
  logic [ID_W-1:0]       win_id_s;
  logic [ID_W-1:0]       idx_s;
  logic                  granted_s;
  logic                  beat_s;
  logic                  last_s;
  logic                  release_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic [DATA_WIDTH-1:0] data_s;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {ID_W{1'b0}};
    idx_s       = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found_s && req_valid_i[idx_s]) begin
        win_found_s = 1'b1;
        win_id_s    = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Write-port steering towards the granted requester, gated by fifo_full.
  always_comb begin
    granted_s = (state_q == ST_GRANT);
    ready_s   = {NUM_REQ{1'b0}};
    data_s    = {DATA_WIDTH{1'b0}};
    last_s    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id_q) begin
        ready_s[i] = granted_s && !fifo_full_i;
        data_s     = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        last_s     = req_last_i[i];
      end else begin
        ready_s[i] = 1'b0;
      end
    end
    beat_s    = |(ready_s & req_valid_i);
    release_s = beat_s && (last_s || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));
  end

  // Next-state logic; rr_ptr only moves on release so idle time never shifts priority.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    msg_done_d    = release_s;
    burst_trunc_d = release_s && !last_s;
    case (state_q)
      ST_IDLE: begin
        if (arb_enable_i && win_found_s) begin
          state_d    = ST_GRANT;
          grant_id_d = win_id_s;
          beat_cnt_d = {CNT_W{1'b0}};
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : grant_id_q + ID_W'(1);
        end else if (beat_s) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= {ID_W{1'b0}};
      rr_ptr_q      <= {ID_W{1'b0}};
      beat_cnt_q    <= {CNT_W{1'b0}};
      msg_done_q    <= 1'b0;
      burst_trunc_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      msg_done_q    <= msg_done_d;
      burst_trunc_q <= burst_trunc_d;
    end
  end

  assign req_ready_o   = ready_s;
  assign fifo_wr_en_o  = beat_s;
  assign fifo_data_o   = data_s;
  assign tx_enable_o   = rst_n;
  assign grant_valid_o = (state_q == ST_GRANT);
  assign grant_id_o    = grant_id_q;
  assign msg_done_o    = msg_done_q;
  assign burst_trunc_o = burst_trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: a driver feeds per-requester byte queues, a monitor
// checks every FIFO write and grant decision against a transaction-level arbitration model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic          UART_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR-1:0] req_ready;
  logic          arb_enable = 1'b0;
  logic          fifo_full = 1'b0;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data;
  logic          tx_enable;
  logic          grant_valid;
  logic [1:0]    grant_id;
  logic          msg_done;
  logic          burst_trunc;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .UART_clk(UART_clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .arb_enable_i(arb_enable), .fifo_full_i(fifo_full),
    .fifo_wr_en_o(fifo_wr_en), .fifo_data_o(fifo_data), .tx_enable_o(tx_enable),
    .grant_valid_o(grant_valid), .grant_id_o(grant_id),
    .msg_done_o(msg_done), .burst_trunc_o(burst_trunc)
  );

  always #5 UART_clk = ~UART_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Stimulus queues (what each requester still has to offer) and expected byte queues.
  logic [8:0] stim_q [NR][$];
  logic [8:0] exp_q  [NR][$];

  // Driver controls
  logic arb_en_ctl = 1'b1;
  logic rand_en    = 1'b0;
  logic force_full = 1'b0;
  int   full_pct   = 0;
  int   gap_pct    = 0;

  // Monitor statistics
  int wr_cnt = 0;
  int done_cnt = 0;
  int trunc_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    stim_q[r].push_back({l, d});
    exp_q[r].push_back({l, d});
  endtask

  task automatic push_msg(input int r, input int len);
    for (int b = 0; b < len; b++)
      push_byte(r, 8'($urandom_range(0, 255)), b == len - 1);
  endtask

  function automatic int rr_winner(input logic [NR-1:0] v, input int rr);
    for (int k = 0; k < NR; k++)
      if (v[(rr + k) % NR]) return (rr + k) % NR;
    return 0;
  endfunction

  // Driver: present queue heads at the falling edge, retire accepted bytes.
  initial begin
    forever begin
      @(negedge UART_clk);
      for (int i = 0; i < NR; i++) begin
        if (stim_q[i].size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = stim_q[i][0][7:0];
          req_last[i] = stim_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*DW +: DW] = 8'($urandom_range(0, 255));
          req_last[i] = 1'($urandom_range(0, 1));
        end
      end
      fifo_full  = force_full || ($urandom_range(0, 99) < full_pct);
      arb_enable = arb_en_ctl && (!rand_en || $urandom_range(0, 9) != 0);
      #1;
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i] && rst_n) void'(stim_q[i].pop_front());
    end
  end

  // Monitor: transaction-level arbitration model plus byte scoreboard.
  initial begin
    logic [NR-1:0] pv;
    logic pen, pgv, edone, etrunc, exp_gv;
    logic [1:0] pgid;
    int mrr, mcnt, exp_gid;
    logic [8:0] item;
    pv = '0; pen = 1'b0; pgv = 1'b0; pgid = '0; edone = 1'b0; etrunc = 1'b0;
    mrr = 0; mcnt = 0;
    forever begin
      @(negedge UART_clk);
      #2;
      if (!rst_n) begin
        pv = '0; pen = 1'b0; pgv = 1'b0; pgid = '0; edone = 1'b0; etrunc = 1'b0;
        mrr = 0; mcnt = 0;
        continue;
      end
      exp_gv = pgv ? !edone : (pen && (|pv));
      exp_gid = (!pgv && exp_gv) ? rr_winner(pv, mrr) : int'(pgid);
      if (!pgv && exp_gv) mcnt = 0;
      chk("grant_valid", 32'(grant_valid), 32'(exp_gv));
      if (exp_gv) chk("grant_id", 32'(grant_id), 32'(exp_gid));
      chk("msg_done", 32'(msg_done), 32'(edone));
      chk("burst_trunc", 32'(burst_trunc), 32'(etrunc));
      chk("tx_enable", 32'(tx_enable), 32'd1);
      chk("req_ready", 32'(req_ready),
          32'((grant_valid && !fifo_full) ? (4'b0001 << grant_id) : 4'b0000));
      chk("fifo_wr_en", 32'(fifo_wr_en),
          32'(grant_valid && req_valid[grant_id] && !fifo_full));
      edone = 1'b0;
      etrunc = 1'b0;
      if (fifo_wr_en) begin
        wr_cnt++;
        if (exp_q[grant_id].size() == 0) begin
          chk("unexpected_write", 32'(fifo_data), 32'hFFFF_FFFF);
        end else begin
          item = exp_q[grant_id].pop_front();
          chk("fifo_data", 32'(fifo_data), 32'(item[7:0]));
          mcnt++;
          if (item[8] || mcnt == MB) begin
            edone = 1'b1;
            etrunc = !item[8];
            mrr = (int'(grant_id) + 1) % NR;
          end
        end
      end
      if (msg_done) done_cnt++;
      if (burst_trunc) trunc_cnt++;
      pv = req_valid; pen = arb_enable; pgv = grant_valid; pgid = grant_id;
    end
  end

  task automatic drain(input string name);
    int cyc;
    logic busy;
    cyc = 0;
    busy = 1'b1;
    while (busy && cyc < 4000) begin
      @(posedge UART_clk);
      cyc++;
      busy = grant_valid;
      for (int i = 0; i < NR; i++)
        if (stim_q[i].size() != 0 || exp_q[i].size() != 0) busy = 1'b1;
    end
    if (busy) chk({name, "_drain_timeout"}, 32'(cyc), 32'd0);
  endtask

  task automatic wait_writes(input int target, input string name);
    int cyc;
    cyc = 0;
    while (wr_cnt < target && cyc < 500) begin
      @(posedge UART_clk);
      cyc++;
    end
    if (wr_cnt < target) chk({name, "_wait_timeout"}, 32'(wr_cnt), 32'(target));
  endtask

  initial begin
    int base, tb0;
    // Reset state
    repeat (3) @(negedge UART_clk);
    #3;
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_msg_done", 32'(msg_done), 32'd0);
    chk("rst_burst_trunc", 32'(burst_trunc), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_fifo_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_tx_enable", 32'(tx_enable), 32'd0);
    rst_n = 1'b1;

    // Single requester, three-byte message
    @(posedge UART_clk);
    base = done_cnt;
    push_byte(2, 8'hA5, 1'b0);
    push_byte(2, 8'h5A, 1'b0);
    push_byte(2, 8'h3C, 1'b1);
    drain("single");
    chk("single_msgs", 32'(done_cnt - base), 32'd1);

    // All requesters, back-to-back one-byte messages
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < NR; r++) push_msg(r, 1);
    drain("rr");

    // fifo_full held for 5 cycles mid-message
    @(posedge UART_clk);
    base = wr_cnt;
    push_msg(0, 8);
    wait_writes(base + 2, "full");
    force_full = 1'b1;
    repeat (5) begin
      @(negedge UART_clk);
      #3;
      chk("full_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("full_ready", 32'(req_ready), 32'd0);
    end
    @(posedge UART_clk);
    force_full = 1'b0;
    drain("full");
    chk("full_bytes", 32'(wr_cnt - base), 32'd8);

    // 20-byte stream against MAX_BURST with another requester pending
    @(posedge UART_clk);
    tb0 = trunc_cnt;
    for (int b = 0; b < 20; b++) push_byte(1, 8'(b), b == 19);
    push_msg(3, 1);
    drain("burst");
    chk("burst_trunc_cnt", 32'(trunc_cnt - tb0), 32'd1);

    // arb_enable dropped after first byte of a 4-byte message
    @(posedge UART_clk);
    base = wr_cnt;
    push_msg(0, 4);
    push_msg(2, 4);
    wait_writes(base + 1, "arb");
    arb_en_ctl = 1'b0;
    wait_writes(base + 4, "arb_msg");
    repeat (2) @(posedge UART_clk);
    repeat (6) begin
      @(negedge UART_clk);
      #3;
      chk("arb_off_grant", 32'(grant_valid), 32'd0);
    end
    chk("arb_off_bytes", 32'(wr_cnt - base), 32'd4);
    @(posedge UART_clk);
    arb_en_ctl = 1'b1;
    drain("arb");

    // Randomised traffic
    rand_en = 1'b1;
    full_pct = 20;
    gap_pct = 15;
    for (int m = 0; m < 40; m++) push_msg($urandom_range(0, NR - 1), $urandom_range(1, 20));
    drain("random");
    rand_en = 1'b0;
    full_pct = 0;
    gap_pct = 0;

    // Reset in the middle of a message
    @(posedge UART_clk);
    base = wr_cnt;
    push_msg(3, 4);
    wait_writes(base + 2, "reset");
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_grant_valid", 32'(grant_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_fifo_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("midrst_tx_enable", 32'(tx_enable), 32'd0);
    @(posedge UART_clk);
    stim_q[3].delete();
    exp_q[3].delete();
    @(negedge UART_clk);
    #3;
    chk("midrst_bytes", 32'(wr_cnt - base), 32'd2);
    rst_n = 1'b1;
    @(posedge UART_clk);
    for (int r = NR - 1; r >= 0; r--) push_msg(r, 1);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
